regfile_scoreboard: RTL and testbench

Parametrised successor to the fixed 32x32 register file. It has configurable data width and depth, an optional hardwired zero register, and optional write-to-read bypass. It adds a per-register busy scoreboard with an outstanding-reservation counter, so the pipeline hazard unit can stall on registers whose producer has not written back yet. It sits in the decode stage: two combinational read ports and one write-back port.

---
 rtl/regfile_scoreboard.sv | 82 ++++++++
 tb/tb_regfile_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with two combinational read ports, one write-back port,
// optional zero register / write bypass, and a per-register busy scoreboard with population count.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [ADDR_WIDTH:0]   busy_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_en, rsv_en, inc, dec;

    // Accesses to a hardwired register 0 are dropped before they reach any state.
    assign wr_en  = ctrl_writeEnable   && !((ZERO_REG != 0) && (ctrl_writeReg   == '0));
    assign rsv_en = ctrl_reserveEnable && !((ZERO_REG != 0) && (ctrl_reserveReg == '0));

    always_comb begin
        busy_d = busy_q;
        if (wr_en)  busy_d[ctrl_writeReg]   = 1'b0;
        if (rsv_en) busy_d[ctrl_reserveReg] = 1'b1;
        inc = rsv_en && !busy_q[ctrl_reserveReg];
        // A reserve of the same register keeps it busy, so the write does not retire it.
        dec = wr_en && busy_q[ctrl_writeReg] && !(rsv_en && (ctrl_reserveReg == ctrl_writeReg));
        count_d = count_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) regs_q[ctrl_writeReg] <= data_writeReg;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        busy_readRegA = busy_q[ctrl_readRegA];
        data_readRegB = regs_q[ctrl_readRegB];
        busy_readRegB = busy_q[ctrl_readRegB];
        if ((BYPASS != 0) && wr_en && (ctrl_readRegA == ctrl_writeReg)) begin
            data_readRegA = data_writeReg;
            busy_readRegA = rsv_en && (ctrl_reserveReg == ctrl_writeReg);
        end
        if ((BYPASS != 0) && wr_en && (ctrl_readRegB == ctrl_writeReg)) begin
            data_readRegB = data_writeReg;
            busy_readRegB = rsv_en && (ctrl_reserveReg == ctrl_writeReg);
        end
        if ((ZERO_REG != 0) && (ctrl_readRegA == '0)) begin
            data_readRegA = '0;
            busy_readRegA = 1'b0;
        end
        if ((ZERO_REG != 0) && (ctrl_readRegB == '0)) begin
            data_readRegB = '0;
            busy_readRegB = 1'b0;
        end
    end

    assign busy_count = count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing instance and a non-bypassing twin share stimulus.
module tb_regfile_scoreboard;
    logic        clock = 1'b0;
    logic        ctrl_reset, ctrl_writeEnable, ctrl_reserveEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, ctrl_reserveReg;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA, data_readRegB, nb_dataA, nb_dataB;
    logic        busy_readRegA, busy_readRegB, nb_busyA, nb_busyB;
    logic [5:0]  busy_count, nb_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
        .busy_readRegA(busy_readRegA), .busy_readRegB(busy_readRegB), .busy_count(busy_count)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(nb_dataA), .data_readRegB(nb_dataB),
        .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
        .busy_readRegA(nb_busyA), .busy_readRegB(nb_busyB), .busy_count(nb_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0; ctrl_reserveEnable = 1'b0;
    endtask

    task automatic reserve(input logic [4:0] r);
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = r;
        tick();
        ctrl_reserveEnable = 1'b0;
        #1;
    endtask

    task automatic write(input logic [4:0] r, input logic [31:0] d);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = r; data_writeReg = d;
        tick();
        ctrl_writeEnable = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        ctrl_writeReg = '0; ctrl_reserveReg = '0; data_writeReg = '0;
        ctrl_readRegA = '0; ctrl_readRegB = '0;
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        #1;

        // Reset sweep
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i); ctrl_readRegB = 5'(31 - i);
            #1;
            check("rst_dataA", data_readRegA, 0);
            check("rst_dataB", data_readRegB, 0);
            check("rst_busyA", busy_readRegA, 0);
            check("rst_busyB", busy_readRegB, 0);
        end
        check("rst_count", busy_count, 0);

        // Write with same-cycle read of r5
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd6;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        #1;
        check("byp_dataA", data_readRegA, 32'hDEADBEEF);
        check("nobyp_dataA", nb_dataA, 32'h0);
        check("byp_otherB", data_readRegB, 32'h0);
        tick();
        ctrl_writeEnable = 1'b0;
        #1;
        check("wr_dataA", data_readRegA, 32'hDEADBEEF);
        check("nobyp_next_dataA", nb_dataA, 32'hDEADBEEF);

        // Zero register
        ctrl_readRegA = 5'd0;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h12345678;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd0;
        #1;
        check("r0_byp_dataA", data_readRegA, 0);
        check("r0_byp_busyA", busy_readRegA, 0);
        tick();
        idle();
        #1;
        check("r0_dataA", data_readRegA, 0);
        check("r0_busyA", busy_readRegA, 0);
        check("r0_count", busy_count, 0);

        // Scoreboard: reserve r3, r7, r3
        reserve(5'd3);
        check("rsv3_count", busy_count, 1);
        reserve(5'd7);
        check("rsv7_count", busy_count, 2);
        reserve(5'd3);
        check("rsv3again_count", busy_count, 2);
        ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd7;
        #1;
        check("r3_busyA", busy_readRegA, 1);
        check("r7_busyB", busy_readRegB, 1);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'hA;
        #1;
        check("wr3_byp_busyA", busy_readRegA, 0);
        check("wr3_nobyp_busyA", nb_busyA, 1);
        tick();
        ctrl_writeEnable = 1'b0;
        #1;
        check("wr3_busyA", busy_readRegA, 0);
        check("wr3_dataA", data_readRegA, 32'hA);
        check("wr3_count", busy_count, 1);
        write(5'd9, 32'h9);
        check("wr9_count", busy_count, 1);

        // Same-register write + reserve on clear r4
        ctrl_readRegA = 5'd4;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h55;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd4;
        #1;
        check("wr4rsv4_byp_dataA", data_readRegA, 32'h55);
        check("wr4rsv4_byp_busyA", busy_readRegA, 1);
        check("wr4rsv4_nobyp_dataA", nb_dataA, 0);
        tick();
        idle();
        #1;
        check("wr4rsv4_dataA", data_readRegA, 32'h55);
        check("wr4rsv4_busyA", busy_readRegA, 1);
        check("wr4rsv4_count", busy_count, 2);

        // Reserve r8 while writing busy r7
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h77;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd8;
        tick();
        idle();
        ctrl_readRegA = 5'd8; ctrl_readRegB = 5'd7;
        #1;
        check("wr7rsv8_count", busy_count, 2);
        check("wr7rsv8_busyA", busy_readRegA, 1);
        check("wr7rsv8_busyB", busy_readRegB, 0);
        check("wr7rsv8_dataB", data_readRegB, 32'h77);

        // Reset mid-operation with 5 busy
        write(5'd2, 32'hFF);
        reserve(5'd1);
        reserve(5'd2);
        reserve(5'd3);
        ctrl_readRegA = 5'd2;
        #1;
        check("pre_rst_count", busy_count, 5);
        check("pre_rst_dataA", data_readRegA, 32'hFF);
        ctrl_reset = 1'b1;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd2; data_writeReg = 32'h1;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd6;
        tick();
        idle();
        #1;
        check("mid_rst_dataA", data_readRegA, 0);
        check("mid_rst_count", busy_count, 0);
        check("mid_rst_nb_count", nb_count, 0);
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            #1;
            check("mid_rst_busyA", busy_readRegA, 0);
        end

        // Fill every register; r0 never counts
        for (int i = 0; i < 32; i++) reserve(5'(i));
        check("full_count", busy_count, 31);
        reserve(5'd31);
        check("full_again_count", busy_count, 31);
        write(5'd31, 32'h31);
        check("full_wr31_count", busy_count, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
